count_sequence_checker: RTL and testbench
=========================================

# count_sequence_checker

Downstream consumer of the 4-bit free-running counter output: samples `count` every clock, checks that each new value is a legal step from the previous one, and reports wrap-around events and sequence errors. It shares clock and reset with the counter and sits beside its testbench in the counter top level, giving the team a synthesizable self-check and event source.

## Interface
- `WIDTH`, 4, width of the monitored count
- `WRAP_CNT_W`, 8, width of the wrap-event counter
- `ERR_CNT_W`, 8, width of the error counter
- `clk`  input  1  single clock; all logic on its rising edge
- `rst`  input  1  reset; synchronous, active-low
- `count`  input  WIDTH  value produced by the upstream counter
- `clr`  input  1  synchronous clear of counters, sticky flag and fault capture
- `wrap_pulse`  output  1  one-cycle pulse on a detected wrap (max → 0)
- `wrap_count`  output  WRAP_CNT_W  number of wraps since reset/clr, modulo 2^WRAP_CNT_W
- `err_pulse`  output  1  one-cycle pulse on an illegal step
- `err_count`  output  ERR_CNT_W  illegal steps since reset/clr, saturating at all-ones
- `err_sticky`  output  1  high from the first error until reset or clr
- `first_err_prev`  output  WIDTH  previous sample at the first error
- `first_err_cur`  output  WIDTH  offending sample at the first error
- `state`  output  2  FSM state: 0 IDLE, 1 TRACK, 2 FAULT

## Operation
- Legal step: `delta = (count - prev) mod 2^WIDTH` is 0 (hold) or 1 (increment). Any other delta is an error, including decrement and skip.
- Wrap: `prev == 2^WIDTH-1` and `count == 0`. A wrap is a legal step; it raises `wrap_pulse` and increments `wrap_count`.
- `prev` is an internal register loaded with `count` every cycle while not in reset.
- FSM:
  - IDLE: entered on reset. Loads `prev` and performs no check. Next state is TRACK unconditionally.
  - TRACK: checks every cycle. An error asserts `err_pulse`, increments `err_count`, sets `err_sticky`, captures `first_err_prev`/`first_err_cur`, and moves to FAULT.
  - FAULT: keeps checking. Further errors pulse and count, but the capture registers stay frozen. `clr` returns the FSM to TRACK.
- `clr` (in TRACK or FAULT):
  - zeroes `wrap_count`, `err_count`, `err_sticky` and both capture registers
  - forces TRACK
  - `prev` still updates
  - has priority over a same-cycle error or wrap: that event is dropped, with no pulse and no count.
  - `clr` in IDLE is ignored.
- `err_count` holds at `2^ERR_CNT_W-1` once reached. `wrap_count` rolls over to 0.
- All outputs are registered.

## Timing
- Reset (`rst`=0 at a rising edge): all outputs are 0 and `state` is IDLE in the following cycle. The same applies for reset asserted mid-operation from any state.
- First check happens on the second edge after reset release. The sample taken in IDLE is never checked, so an arbitrary counter value after reset is not an error.
- Latency: a bad `count` present at edge N produces `err_pulse`=1, updated `err_count`, and (if first) the capture registers, visible after edge N. Pulse width is exactly one cycle.
- Wrap latency is the same: `count`=0 at edge N after `prev`=max gives `wrap_pulse` high after edge N.
- Consecutive errors produce back-to-back pulses with no gap. Each one increments `err_count`.
- A wrap and an error can never occur together, because a wrap is by definition a legal step.

## Test plan
- Reset, then count 0→15→0→1 incrementing each cycle. Required: `wrap_pulse` for one cycle when 0 follows 15; `wrap_count`=1; `err_count`=0; `state`=TRACK.
- Holds mixed in (3,3,3,4,5). Required: no error, `err_sticky`=0.
- Sequence 4,5,7. Required: `err_pulse` after the 7 sample; `first_err_prev`=5, `first_err_cur`=7; `state`=FAULT. Then 7,6: second pulse, `err_count`=2, capture still 5/7.
- `clr` asserted on the same edge as a skip 2→9. Required: no `err_pulse`; counters 0; `err_sticky`=0; `state`=TRACK.
- 300 consecutive bad steps (alternating 0,8). Required: `err_count` saturates at 255. Separately, 257 wraps give `wrap_count`=1.
- Reset asserted mid-FAULT with `err_count`=3. Required: all outputs 0 and IDLE next cycle; the first post-reset sample (e.g. 11) is not flagged.

Source files
------------

// File: rtl/count_sequence_checker.sv
// -----------------------------------------------------------------------------
// count_sequence_checker
//
// Watches the output of a free-running up-counter and checks every step.
// A legal step is either a hold (same value) or an increment by one, modulo
// 2^WIDTH. Wraps (max -> 0) are legal and reported as events. Illegal steps
// are pulsed, counted (saturating) and the first one is captured.
//
// Ports:
//   clk            - single clock, rising edge
//   rst            - synchronous, active-low reset
//   count          - value from the upstream counter
//   clr            - synchronous clear of counters, sticky flag and capture
//   wrap_pulse     - one-cycle pulse on a wrap (max -> 0)
//   wrap_count     - wraps since reset/clr, rolls over
//   err_pulse      - one-cycle pulse on an illegal step
//   err_count      - illegal steps since reset/clr, saturating
//   err_sticky     - set from the first error until reset or clr
//   first_err_prev - previous sample at the first error
//   first_err_cur  - offending sample at the first error
//   state          - 0 IDLE, 1 TRACK, 2 FAULT
// -----------------------------------------------------------------------------
module count_sequence_checker #(
  parameter int WIDTH      = 4,
  parameter int WRAP_CNT_W = 8,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      count,
  input  logic                  clr,
  output logic                  wrap_pulse,
  output logic [WRAP_CNT_W-1:0] wrap_count,
  output logic                  err_pulse,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic                  err_sticky,
  output logic [WIDTH-1:0]      first_err_prev,
  output logic [WIDTH-1:0]      first_err_cur,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      prev_q, prev_d;
  logic                  wrap_pulse_q, wrap_pulse_d;
  logic [WRAP_CNT_W-1:0] wrap_count_q, wrap_count_d;
  logic                  err_pulse_q, err_pulse_d;
  logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
  logic                  err_sticky_q, err_sticky_d;
  logic [WIDTH-1:0]      first_err_prev_q, first_err_prev_d;
  logic [WIDTH-1:0]      first_err_cur_q, first_err_cur_d;

  // Modular difference: wraps naturally, so max -> 0 yields delta 1.
  logic [WIDTH-1:0] delta;
  logic             step_legal;
  logic             step_wrap;

  always_comb begin
    delta      = count - prev_q;
    step_legal = (delta == '0) || (delta == WIDTH'(1));
    step_wrap  = (prev_q == '1) && (count == '0);
  end

  always_comb begin
    state_d          = state_q;
    prev_d           = count;
    wrap_pulse_d     = 1'b0;
    wrap_count_d     = wrap_count_q;
    err_pulse_d      = 1'b0;
    err_count_d      = err_count_q;
    err_sticky_d     = err_sticky_q;
    first_err_prev_d = first_err_prev_q;
    first_err_cur_d  = first_err_cur_q;

    case (state_q)
      ST_IDLE: begin
        // The first sample after reset only seeds prev; clr is ignored here.
        state_d = ST_TRACK;
      end
      ST_TRACK, ST_FAULT: begin
        if (clr) begin
          // Clear wins over any same-cycle event; that event is dropped.
          state_d          = ST_TRACK;
          wrap_count_d     = '0;
          err_count_d      = '0;
          err_sticky_d     = 1'b0;
          first_err_prev_d = '0;
          first_err_cur_d  = '0;
        end else if (!step_legal) begin
          err_pulse_d  = 1'b1;
          err_sticky_d = 1'b1;
          if (err_count_q != '1) begin
            err_count_d = err_count_q + 1'b1;
          end
          // Capture only the first error; FAULT keeps the capture frozen.
          if (state_q == ST_TRACK) begin
            first_err_prev_d = prev_q;
            first_err_cur_d  = count;
            state_d          = ST_FAULT;
          end
        end else if (step_wrap) begin
          wrap_pulse_d = 1'b1;
          wrap_count_d = wrap_count_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= ST_IDLE;
      prev_q           <= '0;
      wrap_pulse_q     <= 1'b0;
      wrap_count_q     <= '0;
      err_pulse_q      <= 1'b0;
      err_count_q      <= '0;
      err_sticky_q     <= 1'b0;
      first_err_prev_q <= '0;
      first_err_cur_q  <= '0;
    end else begin
      state_q          <= state_d;
      prev_q           <= prev_d;
      wrap_pulse_q     <= wrap_pulse_d;
      wrap_count_q     <= wrap_count_d;
      err_pulse_q      <= err_pulse_d;
      err_count_q      <= err_count_d;
      err_sticky_q     <= err_sticky_d;
      first_err_prev_q <= first_err_prev_d;
      first_err_cur_q  <= first_err_cur_d;
    end
  end

  assign wrap_pulse     = wrap_pulse_q;
  assign wrap_count     = wrap_count_q;
  assign err_pulse      = err_pulse_q;
  assign err_count      = err_count_q;
  assign err_sticky     = err_sticky_q;
  assign first_err_prev = first_err_prev_q;
  assign first_err_cur  = first_err_cur_q;
  assign state          = state_q;

endmodule

// File: tb/tb_count_sequence_checker.sv
// -----------------------------------------------------------------------------
// tb_count_sequence_checker
//
// Directed testbench for count_sequence_checker. Inputs change 1 time unit
// after a rising edge; outputs are sampled at the same point, i.e. they show
// the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_count_sequence_checker;

  logic       clk;
  logic       rst;
  logic [3:0] count;
  logic       clr;
  logic       wrap_pulse;
  logic [7:0] wrap_count;
  logic       err_pulse;
  logic [7:0] err_count;
  logic       err_sticky;
  logic [3:0] first_err_prev;
  logic [3:0] first_err_cur;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  count_sequence_checker #(
    .WIDTH(4),
    .WRAP_CNT_W(8),
    .ERR_CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .count(count),
    .clr(clr),
    .wrap_pulse(wrap_pulse),
    .wrap_count(wrap_count),
    .err_pulse(err_pulse),
    .err_count(err_count),
    .err_sticky(err_sticky),
    .first_err_prev(first_err_prev),
    .first_err_cur(first_err_cur),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present a value, take one edge, settle past it.
  task automatic step(input logic [3:0] v);
    count = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wrap_pulse"}, 32'(wrap_pulse), 0);
    chk({tag, ".wrap_count"}, 32'(wrap_count), 0);
    chk({tag, ".err_pulse"},  32'(err_pulse), 0);
    chk({tag, ".err_count"},  32'(err_count), 0);
    chk({tag, ".err_sticky"}, 32'(err_sticky), 0);
    chk({tag, ".fe_prev"},    32'(first_err_prev), 0);
    chk({tag, ".fe_cur"},     32'(first_err_cur), 0);
  endtask

  initial begin
    logic [3:0] v;
    int wraps;

    rst   = 1'b0;
    clr   = 1'b0;
    count = 4'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset.state", 32'(state), 0);
    $display("T1 reset: state=%0d err_count=%0d", state, err_count);

    // Release reset; the IDLE sample is only seeded.
    rst = 1'b1;
    step(4'd0);
    chk("idle_exit.state", 32'(state), 1);
    chk("idle_exit.err_pulse", 32'(err_pulse), 0);

    // Count 1..15, then wrap to 0 and on to 1.
    for (int i = 1; i <= 15; i++) begin
      step(4'(i));
      chk("inc.wrap_pulse", 32'(wrap_pulse), 0);
      chk("inc.err_pulse", 32'(err_pulse), 0);
    end
    step(4'd0);
    chk("wrap.wrap_pulse", 32'(wrap_pulse), 1);
    chk("wrap.wrap_count", 32'(wrap_count), 1);
    step(4'd1);
    chk("after_wrap.wrap_pulse", 32'(wrap_pulse), 0);
    chk("after_wrap.wrap_count", 32'(wrap_count), 1);
    chk("after_wrap.err_count", 32'(err_count), 0);
    chk("after_wrap.state", 32'(state), 1);
    $display("T2 wrap: wrap_count=%0d err_count=%0d state=%0d", wrap_count, err_count, state);

    // Holds mixed in.
    step(4'd2); step(4'd3); step(4'd3); step(4'd3); step(4'd4);
    chk("hold.err_count", 32'(err_count), 0);
    chk("hold.err_sticky", 32'(err_sticky), 0);
    $display("T3 holds: err_count=%0d err_sticky=%0d", err_count, err_sticky);

    // 4,5,7: skip error.
    step(4'd4); step(4'd5);
    chk("pre_skip.err_pulse", 32'(err_pulse), 0);
    step(4'd7);
    chk("skip.err_pulse", 32'(err_pulse), 1);
    chk("skip.err_count", 32'(err_count), 1);
    chk("skip.err_sticky", 32'(err_sticky), 1);
    chk("skip.fe_prev", 32'(first_err_prev), 5);
    chk("skip.fe_cur", 32'(first_err_cur), 7);
    chk("skip.state", 32'(state), 2);
    $display("T4 skip: err_count=%0d capture=%0d/%0d state=%0d", err_count, first_err_prev, first_err_cur, state);

    // 7 (hold), 6 (decrement).
    step(4'd7);
    chk("fault_hold.err_pulse", 32'(err_pulse), 0);
    step(4'd6);
    chk("dec.err_pulse", 32'(err_pulse), 1);
    chk("dec.err_count", 32'(err_count), 2);
    chk("dec.fe_prev", 32'(first_err_prev), 5);
    chk("dec.fe_cur", 32'(first_err_cur), 7);
    chk("dec.state", 32'(state), 2);
    $display("T5 decrement: err_count=%0d capture=%0d/%0d", err_count, first_err_prev, first_err_cur);

    // Go to 2 (third error), then clr together with a 2->9 skip.
    step(4'd2);
    chk("to2.err_count", 32'(err_count), 3);
    clr = 1'b1;
    step(4'd9);
    clr = 1'b0;
    chk_all_zero("clr");
    chk("clr.state", 32'(state), 1);
    step(4'd10);
    chk("post_clr.err_pulse", 32'(err_pulse), 0);
    chk("post_clr.state", 32'(state), 1);
    $display("T6 clr: err_count=%0d err_sticky=%0d state=%0d", err_count, err_sticky, state);

    // 300 consecutive bad steps: 10->0, then 0/8 alternating.
    for (int i = 0; i < 300; i++) begin
      step((i % 2 == 0) ? 4'd0 : 4'd8);
      if (i == 253) chk("sat.err_count_254", 32'(err_count), 254);
      if (i == 254) chk("sat.err_count_255", 32'(err_count), 255);
    end
    chk("sat.err_count", 32'(err_count), 255);
    chk("sat.err_pulse", 32'(err_pulse), 1);
    chk("sat.state", 32'(state), 2);
    $display("T7 saturation: err_count=%0d", err_count);

    // Clear on a legal hold, then 257 wraps.
    clr = 1'b1;
    step(4'd8);
    clr = 1'b0;
    chk("clr2.err_count", 32'(err_count), 0);
    v = 4'd8;
    wraps = 0;
    while (wraps < 257) begin
      v = v + 4'd1;
      step(v);
      if (v == 4'd0) begin
        wraps++;
        if (wraps == 256) chk("wrap256.wrap_count", 32'(wrap_count), 0);
      end
    end
    chk("wrap257.wrap_count", 32'(wrap_count), 1);
    chk("wrap257.wrap_pulse", 32'(wrap_pulse), 1);
    chk("wrap257.err_count", 32'(err_count), 0);
    $display("T8 wraps: wrap_count=%0d err_count=%0d", wrap_count, err_count);

    // Three errors, then reset mid-FAULT.
    step(4'd5); step(4'd0); step(4'd5);
    chk("pre_rst.err_count", 32'(err_count), 3);
    chk("pre_rst.state", 32'(state), 2);
    rst = 1'b0;
    step(4'd5);
    chk_all_zero("mid_rst");
    chk("mid_rst.state", 32'(state), 0);
    rst = 1'b1;
    step(4'd11);
    chk("rst_idle.err_pulse", 32'(err_pulse), 0);
    chk("rst_idle.state", 32'(state), 1);
    step(4'd12);
    chk("rst_first.err_pulse", 32'(err_pulse), 0);
    chk("rst_first.err_count", 32'(err_count), 0);
    step(4'd3);
    chk("rst_chk.err_pulse", 32'(err_pulse), 1);
    chk("rst_chk.fe_prev", 32'(first_err_prev), 12);
    chk("rst_chk.fe_cur", 32'(first_err_cur), 3);
    $display("T9 mid-fault reset: err_count=%0d state=%0d", err_count, state);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
